// File: rtl/vec_load_sequencer.sv
// Input-side frame sequencer: collects A/B/D operand words per lane into shadow
// registers and issues complete frames to the lane datapath with flow control.
module vec_load_sequencer #(
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 issue_ready,
  output logic [W*LANES-1:0]   a_vec,
  output logic [W*LANES-1:0]   b_vec,
  output logic [W*LANES-1:0]   d_vec,
  output logic                 issue,
  output logic [1:0]           phase,
  output logic [1:0]           lane,
  output logic [7:0]           frame_cnt
);

  localparam int unsigned VW     = W * LANES;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_A    = 2'd0,
    ST_B    = 2'd1,
    ST_D    = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e              state_q;
  logic [LANE_W-1:0]   lane_q;
  logic [VW-1:0]       a_sh_q, b_sh_q, d_sh_q;
  logic [VW-1:0]       a_vec_q, b_vec_q, d_vec_q;
  logic                issue_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept;
  logic                last_lane;
  logic [LANE_W-1:0]   lane_nxt;
  logic [VW-1:0]       d_sh_full;

  assign din_ready = !rst && (state_q != ST_HOLD);
  assign accept    = din_valid && din_ready;
  assign last_lane = (lane_q == LANE_W'(LANES - 1));
  assign lane_nxt  = last_lane ? '0 : lane_q + LANE_W'(1);

  // D shadow as it will look once the word for the final lane lands, so a
  // same-edge issue can bypass the shadow register.
  always_comb begin
    d_sh_full = d_sh_q;
    d_sh_full[W*(LANES-1) +: W] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_A;
      lane_q  <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      a_vec_q <= '0;
      b_vec_q <= '0;
      d_vec_q <= '0;
      issue_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      issue_q <= 1'b0;
      unique case (state_q)
        ST_A: begin
          if (accept) begin
            a_sh_q[W*lane_q +: W] <= din;
            lane_q <= lane_nxt;
            if (last_lane) state_q <= ST_B;
          end
        end
        ST_B: begin
          if (accept) begin
            b_sh_q[W*lane_q +: W] <= din;
            lane_q <= lane_nxt;
            if (last_lane) state_q <= ST_D;
          end
        end
        ST_D: begin
          if (accept) begin
            d_sh_q[W*lane_q +: W] <= din;
            lane_q <= lane_nxt;
            if (last_lane) begin
              if (issue_ready) begin
                a_vec_q <= a_sh_q;
                b_vec_q <= b_sh_q;
                d_vec_q <= d_sh_full;
                issue_q <= 1'b1;
                cnt_q   <= cnt_q + CNT_W'(1);
                state_q <= ST_A;
              end else begin
                state_q <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (issue_ready) begin
            a_vec_q <= a_sh_q;
            b_vec_q <= b_sh_q;
            d_vec_q <= d_sh_q;
            issue_q <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_A;
          end
        end
        default: state_q <= ST_A;
      endcase
    end
  end

  assign a_vec     = a_vec_q;
  assign b_vec     = b_vec_q;
  assign d_vec     = d_vec_q;
  assign issue     = issue_q;
  assign phase     = state_q;
  assign lane      = lane_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_vec_load_sequencer.sv
// Self-checking bench for vec_load_sequencer: directed table, corner sequences
// and randomized traffic against a word-list frame model.
module tb_vec_load_sequencer;

  localparam int unsigned W     = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned FW    = W * LANES;
  localparam int unsigned NW    = 3 * LANES;

  logic            clk = 1'b0;
  logic            rst, din_valid, issue_ready;
  logic [W-1:0]    din;
  logic            din_ready, issue;
  logic [FW-1:0]   a_vec, b_vec, d_vec;
  logic [1:0]      phase, lane;
  logic [7:0]      frame_cnt;

  always #5 clk = ~clk;

  vec_load_sequencer #(.W(W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .issue_ready(issue_ready),
    .a_vec(a_vec), .b_vec(b_vec), .d_vec(d_vec), .issue(issue),
    .phase(phase), .lane(lane), .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a list of accepted words plus a "frame waiting" flag.
  logic [W-1:0]  words [NW];
  int            nacc;
  bit            held;
  logic [FW-1:0] m_a, m_b, m_d;
  logic          m_issue;
  logic [7:0]    m_cnt;

  typedef struct {
    logic [7:0] din;
    logic [1:0] ph;
    logic [1:0] ln;
    logic       iss;
  } row_t;
  row_t       tbl [13];
  logic [7:0] fw  [NW];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_transfer();
    for (int i = 0; i < LANES; i++) begin
      m_a[W*i +: W] = words[i];
      m_b[W*i +: W] = words[LANES + i];
      m_d[W*i +: W] = words[2*LANES + i];
    end
    m_issue = 1'b1;
    m_cnt   = m_cnt + 8'd1;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic ir);
    if (r) begin
      nacc = 0; held = 0; m_a = '0; m_b = '0; m_d = '0; m_issue = 0; m_cnt = '0;
    end else begin
      m_issue = 1'b0;
      if (held) begin
        if (ir) begin
          model_transfer();
          held = 0;
          nacc = 0;
        end
      end else if (v) begin
        words[nacc] = d;
        nacc++;
        if (nacc == NW) begin
          if (ir) begin
            model_transfer();
            nacc = 0;
          end else begin
            held = 1;
          end
        end
      end
    end
  endtask

  // One clock: drive, check din_ready, advance model, check registered outputs.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic ir);
    logic [1:0] ep, el;
    rst = r; din_valid = v; din = d; issue_ready = ir;
    #1;
    check("din_ready", 128'(din_ready), 128'(!r && !held));
    @(posedge clk);
    model_step(r, v, d, ir);
    #1;
    ep = held ? 2'd3 : 2'(nacc / LANES);
    el = held ? 2'd0 : 2'(nacc % LANES);
    check("outputs", {19'b0, a_vec, b_vec, d_vec, issue, phase, lane, frame_cnt},
                     {19'b0, m_a, m_b, m_d, m_issue, ep, el, m_cnt});
  endtask

  task automatic check_ref_frame(input string name);
    check({name, "_a"}, 128'(a_vec), 128'(32'h7F00807F));
    check({name, "_b"}, 128'(b_vec), 128'(32'h007F7F80));
    check({name, "_d"}, 128'(d_vec), 128'(32'h20100000));
  endtask

  initial begin
    logic [1:0] pp, pl;
    int k, frames;
    nacc = 0; held = 0; m_a = '0; m_b = '0; m_d = '0; m_issue = 0; m_cnt = '0;

    tbl[0]  = '{8'h7F, 2'd0, 2'd1, 1'b0};
    tbl[1]  = '{8'h80, 2'd0, 2'd2, 1'b0};
    tbl[2]  = '{8'h00, 2'd0, 2'd3, 1'b0};
    tbl[3]  = '{8'h7F, 2'd1, 2'd0, 1'b0};
    tbl[4]  = '{8'h80, 2'd1, 2'd1, 1'b0};
    tbl[5]  = '{8'h7F, 2'd1, 2'd2, 1'b0};
    tbl[6]  = '{8'h7F, 2'd1, 2'd3, 1'b0};
    tbl[7]  = '{8'h00, 2'd2, 2'd0, 1'b0};
    tbl[8]  = '{8'h00, 2'd2, 2'd1, 1'b0};
    tbl[9]  = '{8'h00, 2'd2, 2'd2, 1'b0};
    tbl[10] = '{8'h10, 2'd2, 2'd3, 1'b0};
    tbl[11] = '{8'h20, 2'd0, 2'd0, 1'b1};
    tbl[12] = '{8'h11, 2'd0, 2'd1, 1'b0};
    for (int i = 0; i < NW; i++) fw[i] = tbl[i].din;

    // Reset held two cycles with valid input present
    cyc(1, 1, 8'hAA, 1);
    cyc(1, 1, 8'hAA, 1);
    check("rst_vec", 128'({a_vec, b_vec, d_vec}), 128'(0));
    check("rst_ctl", 128'({issue, phase, lane, frame_cnt}), 128'(0));

    // Continuous reference frame from the table
    for (int i = 0; i < 13; i++) begin
      cyc(0, 1, tbl[i].din, 1);
      check("tbl_phase", 128'(phase), 128'(tbl[i].ph));
      check("tbl_lane",  128'(lane),  128'(tbl[i].ln));
      check("tbl_issue", 128'(issue), 128'(tbl[i].iss));
      if (i == 11) begin
        check_ref_frame("cont");
        check("cont_cnt", 128'(frame_cnt), 128'(8'd1));
      end
    end

    // Back-to-back second frame: issue exactly 12 cycles after the first
    for (int j = 0; j < 11; j++) begin
      cyc(0, 1, 8'($urandom), 1);
      check("b2b_issue", 128'(issue), 128'(j == 10));
    end
    check("b2b_cnt", 128'(frame_cnt), 128'(8'd2));

    // Same frame with 5 bubbles: issue 5 cycles later, lane/phase frozen
    k = 0;
    for (int c = 0; c < 17; c++) begin
      if (c == 2 || c == 5 || c == 9 || c == 10 || c == 14) begin
        pp = phase; pl = lane;
        cyc(0, 0, 8'hEE, 1);
        check("bub_frozen", 128'({phase, lane}), 128'({pp, pl}));
      end else begin
        cyc(0, 1, fw[k], 1);
        k++;
      end
      check("bub_issue", 128'(issue), 128'(c == 16));
    end
    check_ref_frame("bub");
    check("bub_cnt", 128'(frame_cnt), 128'(8'd3));

    // Back-pressure: completion with issue_ready low, then hold 5 cycles
    for (int j = 0; j < NW - 1; j++) cyc(0, 1, fw[j], 1);
    cyc(0, 1, fw[NW-1], 0);
    check("hold_phase", 128'(phase), 128'(2'd3));
    for (int j = 0; j < 5; j++) begin
      cyc(0, 1, 8'h5A, 0);
      check("hold_stay", 128'({phase, issue, frame_cnt}), 128'({2'd3, 1'b0, 8'd3}));
    end
    cyc(0, 1, 8'h5A, 1);
    check("hold_issue", 128'({issue, phase, lane}), 128'({1'b1, 2'd0, 2'd0}));
    check_ref_frame("hold");
    cyc(0, 1, 8'h5A, 1);
    check("hold_resume", 128'({issue, phase, lane}), 128'({1'b0, 2'd0, 2'd1}));
    for (int j = 1; j < NW; j++) cyc(0, 1, 8'(j), 1);
    check("held_word", 128'(a_vec[7:0]), 128'(8'h5A));

    // Mid-frame reset after 7 accepts, then a clean frame
    for (int j = 0; j < 7; j++) cyc(0, 1, 8'hC3, 1);
    cyc(1, 1, 8'hC3, 1);
    check("mid_rst", 128'({a_vec, b_vec, d_vec, frame_cnt, phase, lane}), 128'(0));
    for (int j = 0; j < NW; j++) cyc(0, 1, fw[j], 1);
    check_ref_frame("mid");
    check("mid_cnt", 128'({issue, frame_cnt}), 128'({1'b1, 8'd1}));

    // Reset coinciding with frame completion: reset wins
    for (int j = 0; j < NW - 1; j++) cyc(0, 1, 8'h33, 1);
    cyc(1, 1, 8'h44, 1);
    check("rst_win", 128'({issue, frame_cnt, a_vec}), 128'(0));

    // Randomized traffic
    for (int j = 0; j < 800; j++)
      cyc(($urandom % 60) == 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);

    // Counter wrap across 256 frames
    cyc(1, 0, 8'h00, 1);
    frames = 0;
    for (int f = 1; f <= 256; f++) begin
      for (int j = 0; j < NW; j++) cyc(0, 1, 8'($urandom), 1);
      if (issue === 1'b1) frames++;
      if (f == 255) check("wrap_255", 128'(frame_cnt), 128'(8'd255));
      if (f == 256) check("wrap_0", 128'(frame_cnt), 128'(8'd0));
    end
    check("wrap_frames", 128'(frames), 128'(256));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_load_sequencer.md
# vec_load_sequencer

Input-side controller for the 4-lane vector datapath. It consumes the serial signed 8-bit operand stream (all A words for the 4 lanes, then all B words, then all D words), assembles one complete frame in shadow registers, and issues it to the lane datapath as packed operand vectors with a one-cycle `issue` strobe. It also applies valid/ready flow control: input is back-pressured when a finished frame cannot be issued yet.

## Interface
- `W`, 8: operand width in bits, signed two's complement.
- `LANES`, 4: number of lanes; one frame is 3*LANES accepted words.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  W  signed operand word.
- `din_valid`  in  1  `din` carries a word this cycle.
- `din_ready`  out  1  sequencer accepts a word this cycle.
- `issue_ready`  in  1  datapath can take a new frame.
- `a_vec`, `b_vec`, `d_vec`  out  W*LANES  issued operands; lane i is in bits [W*i +: W].
- `issue`  out  1  one-cycle pulse: new frame present on `*_vec`.
- `phase`  out  2  current collect phase: 0 = A, 1 = B, 2 = D, 3 = HOLD.
- `lane`  out  2  lane index the next accepted word fills.
- `frame_cnt`  out  8  number of frames issued, modulo 256.

## Operation
- Accept: a word is taken on a rising edge when `din_valid && din_ready`. `din_ready = !rst && (phase != HOLD)`, combinational.
- FSM states: COLLECT_A -> COLLECT_B -> COLLECT_D -> (COLLECT_A or HOLD).
  - In each COLLECT state, the accepted word goes into shadow lane `lane`, and `lane` increments.
  - When the word for lane LANES-1 is accepted, `lane` returns to 0 and the FSM moves to the next phase.
  - Cycles without an accept change nothing.
- Frame completion is the accept of D for lane LANES-1:
  - If `issue_ready` = 1 on that same edge: on that edge, copy all shadow registers (including the word being accepted) into `a_vec`/`b_vec`/`d_vec`, set `issue` = 1, increment `frame_cnt`, and go to COLLECT_A.
  - Otherwise go to HOLD with the shadow registers intact.
- HOLD:
  - `din_ready` = 0; `din_valid` words are not consumed.
  - On the first edge with `issue_ready` = 1: do the same transfer as above, set `issue` = 1, increment `frame_cnt`, and go to COLLECT_A.
- `*_vec` change only at a transfer and are stable between issues.
- `issue` is high for exactly the one cycle after each transfer edge.
- `frame_cnt` wraps from 255 to 0.
- The sequencer performs no arithmetic. Words are stored bit-exact, with no sign handling beyond passing them through.
- Reset (any cycle, including mid-frame or in HOLD):
  - State: FSM -> COLLECT_A, `lane` = 0, shadow registers = 0.
  - Outputs: `a_vec` = `b_vec` = `d_vec` = 0, `issue` = 0, `frame_cnt` = 0, `phase` = 0, `lane` = 0, `din_ready` = 0 while `rst` is high.
  - A partial frame is discarded.
  - The first accepted word after reset is A for lane 0.

## Timing
- With `din_valid` and `issue_ready` held high, the sequencer accepts one word per cycle.
  - `issue` rises in the cycle after the 12th accept.
  - The next frame's first A word is accepted in that same cycle, so frames issue every 12 cycles with no bubble.
- Issue from HOLD:
  - `issue` is high in the cycle after the edge on which `issue_ready` is sampled high.
  - `din_ready` returns high in that same cycle: one bubble relative to the no-stall case.
- `phase` and `lane` are registered and reflect state after the last edge.
- Simultaneous `rst` and frame completion: reset wins; there is no issue and no count increment.

## Test plan
- Reset: hold `rst` 2 cycles with `din_valid` = 1 -> all outputs 0, `din_ready` = 0 during reset, `phase` = 0 and `lane` = 0 after release.
- Continuous frame: stream A = {127, -128, 0, 127}, B = {-128, 127, 127, 0}, D = {0, 0, 16, 32} with `issue_ready` = 1 -> cycle after the 12th accept shows `issue` = 1, `a_vec` = 0x7F00807F, `b_vec` = 0x007F7F80, `d_vec` = 0x20100000, `frame_cnt` = 1. A second back-to-back frame issues exactly 12 cycles later.
- Bubbles: same frame with `din_valid` low on 5 scattered cycles -> identical vectors, `issue` delayed by exactly 5 cycles, `lane`/`phase` frozen during the bubbles.
- Back-pressure: `issue_ready` = 0 at frame completion -> `phase` = 3, `din_ready` = 0, held `din` not consumed. Raise `issue_ready` after 5 cycles -> `issue` next cycle, then that held word is accepted as A lane 0 of the following frame.
- Mid-frame reset: reset after 7 accepts -> outputs 0. The next 12 words form a clean frame whose vectors match those words only.
- Wrap: issue 256 frames -> `frame_cnt` reads 255 after the 255th frame and 0 after the 256th.
